// File: rtl/bcd_conv_multi.sv
// bcd_conv_multi: CH-channel shift-add-3 binary to packed-BCD converter with
// valid/ready request, overflow saturation, and optional blanking (BCD_LEAD_BLANK_EN).
// Ports: sys_clk, sys_rst_n, in_valid/in_ready, data -> out_valid, busy,
//        bcd_data, ovf, blank_mask.
module bcd_conv_multi #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5,
  parameter int CH     = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*DATA_W-1:0]     data,
  output logic                     out_valid,
  output logic                     busy,
  output logic [CH*DIGITS*4-1:0]   bcd_data,
  output logic [CH-1:0]            ovf,
  output logic [CH*DIGITS-1:0]     blank_mask
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int AW = DIGITS * 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_bin [CH];
  logic [AW-1:0]     r_acc [CH];
  logic [CH-1:0]     r_ovf_work;

  logic [CH*AW-1:0]  r_bcd;
  logic [CH-1:0]     r_ovf;

  logic [AW-1:0]     w_corr    [CH];
  logic [AW-1:0]     w_acc_nxt [CH];
  logic [DATA_W-1:0] w_bin_nxt [CH];
  logic [CH-1:0]     w_carry;
  logic [CH-1:0]     w_ovf_nxt;
  logic [AW-1:0]     w_res     [CH];
  logic              w_last;
  logic              w_accept;

  assign w_last   = (r_cnt == CW'(DATA_W - 1));
  assign w_accept = (r_state == S_IDLE) && in_valid;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One double-dabble step per channel; the carry out of the top
  // digit means the value cannot fit in DIGITS decimal digits.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      w_corr[k] = r_acc[k];
      for (int i = 0; i < DIGITS; i++) begin
        if (r_acc[k][i*4 +: 4] >= 4'd5)
          w_corr[k][i*4 +: 4] = r_acc[k][i*4 +: 4] + 4'd3;
      end
      {w_carry[k], w_acc_nxt[k], w_bin_nxt[k]} =
        {w_corr[k], r_bin[k], 1'b0};
      w_ovf_nxt[k] = r_ovf_work[k] | w_carry[k];
      w_res[k] = w_ovf_nxt[k] ? {DIGITS{4'h9}} : w_acc_nxt[k];
    end
  end

`ifdef BCD_LEAD_BLANK_EN
  logic [CH*DIGITS-1:0] r_blank;
  logic [CH*DIGITS-1:0] w_blank;
  logic                 w_zero;

  // Walk down from the top digit; a digit blanks while all digits
  // from it upward are zero. Digit 0 always stays visible.
  always_comb begin
    w_blank = '0;
    w_zero  = 1'b1;
    for (int k = 0; k < CH; k++) begin
      w_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        w_zero = w_zero & (w_acc_nxt[k][i*4 +: 4] == 4'd0);
        w_blank[k*DIGITS + i] = w_zero & ~w_ovf_nxt[k];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_blank <= '0;
    else if (r_state == S_SHIFT && w_last)
      r_blank <= w_blank;
  end

  assign blank_mask = r_blank;
`else
  assign blank_mask = '0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt      <= '0;
      r_ovf_work <= '0;
      r_bcd      <= '0;
      r_ovf      <= '0;
      for (int k = 0; k < CH; k++) begin
        r_bin[k] <= '0;
        r_acc[k] <= '0;
      end
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_ovf_work <= '0;
      for (int k = 0; k < CH; k++) begin
        r_bin[k] <= data[k*DATA_W +: DATA_W];
        r_acc[k] <= '0;
      end
    end else if (r_state == S_SHIFT) begin
      r_cnt      <= r_cnt + 1'b1;
      r_ovf_work <= w_ovf_nxt;
      for (int k = 0; k < CH; k++) begin
        r_bin[k] <= w_bin_nxt[k];
        r_acc[k] <= w_acc_nxt[k];
      end
      // Results land with the final shift so they are stable
      // for the whole DONE cycle.
      if (w_last) begin
        r_ovf <= w_ovf_nxt;
        for (int k = 0; k < CH; k++)
          r_bcd[k*AW +: AW] <= w_res[k];
      end
    end
  end

  assign bcd_data = r_bcd;
  assign ovf      = r_ovf;

endmodule
